// File: rtl/fifo_burst_reader_if.sv
// Purpose: FIFO read port plus valid/ready output stream of the burst reader.
// Latency: wiring only, no state.
// Backpressure: DOUT_READY flows from the consumer to the reader (slave drives it).
interface fifo_burst_reader_if #(
  parameter int SIZE = 8
);
  logic            READ;
  logic            F_EMPTY_N;
  logic [SIZE-1:0] FIFO_DATA;
  logic [SIZE-1:0] DOUT;
  logic            DOUT_VALID;
  logic            DOUT_READY;

  // Reader side: strobes the FIFO and sources the stream.
  modport master (
    output READ,
    input  F_EMPTY_N,
    input  FIFO_DATA,
    output DOUT,
    output DOUT_VALID,
    input  DOUT_READY
  );

  // Environment side: the FIFO plus the downstream consumer.
  modport slave (
    input  READ,
    output F_EMPTY_N,
    output FIFO_DATA,
    input  DOUT,
    input  DOUT_VALID,
    output DOUT_READY
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Purpose: drains BURST_LEN words from a shift-register FIFO onto a valid/ready stream.
// Latency: START in cycle 0 -> READ in cycle 1 -> DOUT_VALID in cycle 3; 1 word/cycle sustained.
// Backpressure: DOUT held while DOUT_READY=0; READ throttled so buffered+in-flight words never exceed 2.
module fifo_burst_reader #(
  parameter int SIZE    = 8,
  parameter int BURST_W = 8
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               CLEAR_N,
  input  logic               START,
  input  logic [BURST_W-1:0] BURST_LEN,
  fifo_burst_reader_if.master bus,
  output logic               BUSY,
  output logic               DONE,
  output logic [BURST_W-1:0] WORD_CNT
);

  typedef enum logic [1:0] {IDLE, READING, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] req_cnt;
  logic               pend;       // a FIFO read was issued last cycle; data lands now
  logic [1:0]         occ;        // words held in the 2-entry output buffer
  logic [SIZE-1:0]    head;
  logic [SIZE-1:0]    tail;
  logic               pop;
  logic               rd;
  logic               last_pop;
  logic               start_ok;
  logic [2:0]         committed;  // words that will occupy the buffer after this edge

  assign bus.READ       = rd;
  assign bus.DOUT       = head;
  assign bus.DOUT_VALID = (occ != 2'd0);
  assign BUSY           = (state != IDLE);

  // Handshake, read throttling and burst completion decode.
  always_comb begin
    pop       = 1'b0;
    committed = 3'd0;
    rd        = 1'b0;
    last_pop  = 1'b0;
    start_ok  = 1'b0;
    pop       = (occ != 2'd0) & bus.DOUT_READY;
    committed = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    // CLEAR_N gates READ so the FIFO never loses a word into a buffer being flushed.
    rd        = CLEAR_N & (state == READING) & bus.F_EMPTY_N &
                (req_cnt < len) & (committed < 3'd2);
    last_pop  = pop & (state != IDLE) & (WORD_CNT == len - 1'b1);
    start_ok  = (state == IDLE) & START & (BURST_LEN != '0);
  end

  // Next-state logic: completion wins over the READING->DRAIN hand-off.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = READING;
      READING: begin
        if (last_pop)                               state_nxt = IDLE;
        else if (rd && (req_cnt == len - 1'b1))     state_nxt = DRAIN;
      end
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)      state <= IDLE;
    else if (!CLEAR_N) state <= IDLE;
    else               state <= state_nxt;
  end

  // Burst length, request/accept counters, in-flight flag and DONE pulse.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      len      <= '0;
      req_cnt  <= '0;
      WORD_CNT <= '0;
      pend     <= 1'b0;
      DONE     <= 1'b0;
    end else if (!CLEAR_N) begin
      len      <= '0;
      req_cnt  <= '0;
      WORD_CNT <= '0;
      pend     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      pend <= rd;
      DONE <= last_pop;
      if (start_ok) begin
        len      <= BURST_LEN;
        req_cnt  <= '0;
        WORD_CNT <= '0;
      end else begin
        if (rd)  req_cnt  <= req_cnt + 1'b1;
        if (pop) WORD_CNT <= WORD_CNT + 1'b1;
      end
    end
  end

  // Two-entry output buffer: FIFO word enters at the tail, stream reads the head.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (!CLEAR_N) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) head <= bus.FIFO_DATA;
          else             tail <= bus.FIFO_DATA;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= bus.FIFO_DATA;
          end else begin
            head <= tail;
            tail <= bus.FIFO_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Purpose: scoreboard bench for fifo_burst_reader with a behavioural shift-register FIFO.
// Latency: expectations hand-computed from START cycle 0 (READ from cycle 1, DOUT from cycle 3).
// Backpressure: DOUT_READY patterns exercise stalls; monitor checks hold, ordering and READ room.
module tb_fifo_burst_reader;
  localparam int SIZE    = 8;
  localparam int BURST_W = 8;

  logic               CLOCK = 1'b0;
  logic               RESET_N;
  logic               CLEAR_N;
  logic               START;
  logic [BURST_W-1:0] BURST_LEN;
  logic               BUSY;
  logic               DONE;
  logic [BURST_W-1:0] WORD_CNT;

  always #5 CLOCK = ~CLOCK;

  fifo_burst_reader_if #(.SIZE(SIZE)) bus ();

  fifo_burst_reader #(.SIZE(SIZE), .BURST_W(BURST_W)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .CLEAR_N   (CLEAR_N),
    .START     (START),
    .BURST_LEN (BURST_LEN),
    .bus       (bus),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .WORD_CNT  (WORD_CNT)
  );

  // Behavioural FIFO: registered DATA_OUT, write visible after the edge.
  logic [SIZE-1:0] fifo_q[$];
  logic [SIZE-1:0] fifo_data;
  logic            wr_en;
  logic [SIZE-1:0] wr_dat;
  logic            rdy;
  int              f_cnt;

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      fifo_q.delete();
      fifo_data <= '0;
      f_cnt     <= 0;
    end else if (!CLEAR_N) begin
      fifo_q.delete();
      fifo_data <= '0;
      f_cnt     <= 0;
    end else begin
      if (bus.READ && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_dat);
      f_cnt <= fifo_q.size();
    end
  end

  assign bus.F_EMPTY_N  = (f_cnt != 0);
  assign bus.FIFO_DATA  = fifo_data;
  assign bus.DOUT_READY = rdy;

  // Scoreboard state
  logic [SIZE-1:0] exp_q[$];
  int              rd_log[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              c0 = 0;
  int              done_cnt = 0;
  int              done_cyc = -1;
  int              first_vld = -1;
  int              n_rd = 0;
  int              n_pop = 0;
  logic            prev_stall = 1'b0;
  logic [SIZE-1:0] prev_dout = '0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every accept.
  always @(negedge CLOCK) begin
    if (!RESET_N || !CLEAR_N) begin
      n_rd       = 0;
      n_pop      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(bus.DOUT_VALID), 1);
        check("stall_data", int'(bus.DOUT), int'(prev_dout));
      end
      if (bus.READ) begin
        check("read_nonempty", int'(bus.F_EMPTY_N), 1);
        check("read_room",
              int'((n_rd - n_pop - ((bus.DOUT_VALID && bus.DOUT_READY) ? 1 : 0)) < 2), 1);
        n_rd++;
        rd_log.push_back(cyc - c0);
      end
      if (bus.DOUT_VALID && first_vld < 0) first_vld = cyc - c0;
      if (bus.DOUT_VALID && bus.DOUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got 0x%0h, required no word", bus.DOUT);
        end else begin
          check("dout", int'(bus.DOUT), int'(exp_q.pop_front()));
        end
        n_pop++;
      end
      prev_stall = bus.DOUT_VALID && !bus.DOUT_READY;
      prev_dout  = bus.DOUT;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc - c0;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push_word(input logic [SIZE-1:0] w, input bit expect_it);
    wr_en  = 1'b1;
    wr_dat = w;
    if (expect_it) exp_q.push_back(w);
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic start_burst(input logic [BURST_W-1:0] n);
    START     = 1'b1;
    BURST_LEN = n;
    c0        = cyc;
    first_vld = -1;
    rd_log.delete();
    tick();
    START     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) tick();
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic clear_pulse();
    CLEAR_N = 1'b0;
    tick();
    CLEAR_N = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    int d0;
    pat       = 4'b1001;  // DOUT_READY sequence 1,0,0,1 (bit 0 first)
    RESET_N   = 1'b0;
    CLEAR_N   = 1'b1;
    START     = 1'b0;
    BURST_LEN = '0;
    wr_en     = 1'b0;
    wr_dat    = '0;
    rdy       = 1'b1;
    #1;
    check("rst_read", int'(bus.READ), 0);
    check("rst_dout", int'(bus.DOUT), 0);
    check("rst_valid", int'(bus.DOUT_VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_wcnt", int'(WORD_CNT), 0);
    tick();
    RESET_N = 1'b1;
    tick();

    // Basic 4-word burst: exact cycle timing
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i), 1'b1);
    start_burst(8'd4);
    wait_done(30);
    check("t1_nreads", rd_log.size(), 4);
    for (int i = 0; i < rd_log.size() && i < 4; i++) check("t1_read_cyc", rd_log[i], i + 1);
    check("t1_first_valid", first_vld, 3);
    check("t1_done_cyc", done_cyc, 7);
    check("t1_wcnt", int'(WORD_CNT), 4);
    check("t1_busy", int'(BUSY), 0);
    check("t1_left", exp_q.size(), 0);

    // Partial drain: 3 of 6 words
    for (int i = 0; i < 6; i++) push_word(8'h31 + 8'(i), i < 3);
    start_burst(8'd3);
    wait_done(30);
    check("t2_nreads", rd_log.size(), 3);
    check("t2_fifo_left", f_cnt, 3);
    check("t2_wcnt", int'(WORD_CNT), 3);
    check("t2_left", exp_q.size(), 0);
    clear_pulse();

    // Backpressure 1,0,0,1 over 8 words
    for (int i = 0; i < 8; i++) push_word(8'h51 + 8'(i), 1'b1);
    start_burst(8'd8);
    d0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      rdy = pat[i % 4];
      tick();
    end
    check("t3_done_seen", done_cnt - d0, 1);
    rdy = 1'b1;
    check("t3_nreads", rd_log.size(), 8);
    check("t3_wcnt", int'(WORD_CNT), 8);
    check("t3_left", exp_q.size(), 0);

    // Underrun: FIFO empty at START, words trickle in at cycles 5 and 9
    start_burst(8'd2);
    while (cyc - c0 < 5) tick();
    check("t4_busy_wait", int'(BUSY), 1);
    push_word(8'hA5, 1'b1);
    while (cyc - c0 < 9) tick();
    check("t4_busy_mid", int'(BUSY), 1);
    push_word(8'h5A, 1'b1);
    wait_done(30);
    check("t4_nreads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("t4_read0_cyc", rd_log[0], 6);
      check("t4_read1_cyc", rd_log[1], 10);
    end
    check("t4_done_cyc", done_cyc, 13);
    check("t4_left", exp_q.size(), 0);

    // Synchronous clear mid-burst, then a normal burst
    for (int i = 0; i < 10; i++) push_word(8'h71 + 8'(i), 1'b1);
    start_burst(8'd10);
    for (int i = 0; i < 50 && WORD_CNT != 8'd4; i++) tick();
    check("t5_reach4", int'(WORD_CNT), 4);
    d0 = done_cnt;
    clear_pulse();
    exp_q.delete();
    check("t5_valid", int'(bus.DOUT_VALID), 0);
    check("t5_wcnt", int'(WORD_CNT), 0);
    check("t5_busy", int'(BUSY), 0);
    check("t5_read", int'(bus.READ), 0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_done", done_cnt - d0, 0);
    push_word(8'h21, 1'b1);
    push_word(8'h22, 1'b1);
    start_burst(8'd2);
    wait_done(30);
    check("t5_wcnt_new", int'(WORD_CNT), 2);
    check("t5_left", exp_q.size(), 0);

    // Asynchronous reset mid-burst: outputs drop before any clock edge
    for (int i = 0; i < 10; i++) push_word(8'h91 + 8'(i), 1'b1);
    start_burst(8'd10);
    for (int i = 0; i < 3; i++) tick();
    check("t6_busy_pre", int'(BUSY), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_read", int'(bus.READ), 0);
    check("t6_dout", int'(bus.DOUT), 0);
    check("t6_valid", int'(bus.DOUT_VALID), 0);
    check("t6_busy", int'(BUSY), 0);
    check("t6_done", int'(DONE), 0);
    check("t6_wcnt", int'(WORD_CNT), 0);
    exp_q.delete();
    tick();
    RESET_N = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
